cnn_layer_sequencer: RTL and testbench

- Top-level controller for the CNN inference pipeline (conv1, pool1, conv2, pool2, fc).
- Launches each layer block in order with a one-cycle start pulse and waits for that layer's done pulse.
- Enforces a per-layer timeout watchdog and reports a single inference-complete pulse, or an error naming the failing layer.

---
 rtl/cnn_layer_sequencer_if.sv | 42 ++++
 rtl/cnn_layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the inference sequencer and its layer blocks.
// With SEQ_PERF_CNT_EN defined the bundle also carries the perf-counter signals.
interface cnn_layer_sequencer_if #(
   parameter int unsigned NUM_STAGES = 5
);
   localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   logic                  start;
   logic                  abort;
   logic [NUM_STAGES-1:0] stage_start;
   logic [NUM_STAGES-1:0] stage_done;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic [SW-1:0]         err_stage;
   logic [SW-1:0]         cur_stage;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]           perf_cycles;
   logic [SW-1:0]         perf_stage_sel;
   logic [31:0]           perf_stage_cycles;
`endif

   // Sequencer side
   modport master (
      input  start, abort, stage_done,
`ifdef SEQ_PERF_CNT_EN
      input  perf_stage_sel,
      output perf_cycles, perf_stage_cycles,
`endif
      output stage_start, busy, done, error, err_stage, cur_stage
   );

   // Host / layer-block side
   modport slave (
      output start, abort, stage_done,
`ifdef SEQ_PERF_CNT_EN
      output perf_stage_sel,
      input  perf_cycles, perf_stage_cycles,
`endif
      input  stage_start, busy, done, error, err_stage, cur_stage
   );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// CNN inference sequencer: launches layer blocks 0..NUM_STAGES-1 in order,
// waits for each done with a per-stage watchdog, and reports done or error.
// Optional macro SEQ_PERF_CNT_EN adds run/per-stage cycle counters.
module cnn_layer_sequencer #(
   parameter int unsigned          NUM_STAGES = 5,
   parameter int unsigned          TIMEOUT_W  = 20,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 20'd1000000
) (
   input logic                   clk,
   input logic                   reset,
   cnn_layer_sequencer_if.master bus
);
   localparam int unsigned          SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [SW-1:0]        LAST_IDX  = SW'(NUM_STAGES - 1);
   localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT - TIMEOUT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        idx_q, idx_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic [SW-1:0]        err_stage_q, err_stage_d;

   logic done_sel;
   assign done_sel = bus.stage_done[idx_q];

`ifdef SEQ_PERF_CNT_EN
   logic        accept;
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [31:0] stage_cyc_q [NUM_STAGES];
   logic [31:0] stage_cyc_d [NUM_STAGES];

   assign accept = (state_q == S_IDLE) && bus.start && !bus.abort;
`endif

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         wdog_q      <= '0;
         err_stage_q <= '0;
`ifdef SEQ_PERF_CNT_EN
         perf_cycles_q <= '0;
         stage_cyc_q   <= '{default: '0};
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wdog_q      <= wdog_d;
         err_stage_q <= err_stage_d;
`ifdef SEQ_PERF_CNT_EN
         perf_cycles_q <= perf_cycles_d;
         stage_cyc_q   <= stage_cyc_d;
`endif
      end
   end

   // Next-state logic; abort outranks stage done and watchdog expiry
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wdog_d      = wdog_q;
      err_stage_d = err_stage_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            wdog_d  = '0;
            state_d = bus.abort ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (done_sel) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_q + SW'(1);
                  state_d = S_LAUNCH;
               end
            end else if (wdog_q == WDOG_LAST) begin
               state_d     = S_ERROR;
               err_stage_d = idx_q;
            end else begin
               wdog_d = wdog_q + TIMEOUT_W'(1);
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            if (bus.abort) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // idx is parked at 0 whenever the sequencer is (or becomes) idle
      if (state_d == S_IDLE) idx_d = '0;
   end

   // Outputs decoded purely from registered state
   always_comb begin
      bus.stage_start = '0;
      if (state_q == S_LAUNCH) bus.stage_start = NUM_STAGES'(1) << idx_q;
      bus.busy      = (state_q != S_IDLE);
      bus.done      = (state_q == S_FINISH);
      bus.error     = (state_q == S_ERROR);
      bus.err_stage = err_stage_q;
      bus.cur_stage = idx_q;
   end

`ifdef SEQ_PERF_CNT_EN
   // Run and per-stage WAIT cycle counters, cleared when a start is accepted
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      stage_cyc_d   = stage_cyc_q;
      if (accept) begin
         perf_cycles_d = '0;
         stage_cyc_d   = '{default: '0};
      end else if (state_q != S_IDLE) begin
         perf_cycles_d = perf_cycles_q + 32'd1;
         if (state_q == S_WAIT) stage_cyc_d[idx_q] = stage_cyc_q[idx_q] + 32'd1;
      end
   end

   // Counter read-out; out-of-range selects return zero
   always_comb begin
      bus.perf_cycles       = perf_cycles_q;
      bus.perf_stage_cycles = '0;
      if (32'(bus.perf_stage_sel) < NUM_STAGES) bus.perf_stage_cycles = stage_cyc_q[bus.perf_stage_sel];
   end
`endif
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer (TIMEOUT=16, NUM_STAGES=5).
// Expected per-cycle traces are derived from stage latencies and abort cycles.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;
   localparam int NS    = 5;
   localparam int TO    = 16;
   localparam int MAXH  = 256;
   localparam int NEVER = 100000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cnn_layer_sequencer_if #(.NUM_STAGES(NS)) bus_if ();

   cnn_layer_sequencer #(
      .NUM_STAGES(NS),
      .TIMEOUT_W (20),
      .TIMEOUT   (20'd16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: stage latencies, abort cycle, stray dones, expected trace
   int            lat [NS];
   int            ab;
   int            err_start;
   logic [NS-1:0] stray  [MAXH];
   bit            xstart [MAXH];
   logic [NS-1:0] e_ss   [MAXH];
   bit            e_done [MAXH];
   bit            e_busy [MAXH];
   bit            e_err  [MAXH];
   int            e_es   [MAXH];
   int            e_cur  [MAXH];

   function automatic void clear_model();
      for (int i = 0; i < MAXH; i++) begin
         stray[i] = '0; xstart[i] = 1'b0; e_ss[i] = '0;
         e_done[i] = 1'b0; e_busy[i] = 1'b0; e_err[i] = 1'b0;
         e_es[i] = 0; e_cur[i] = 0;
      end
      ab = -1;
      err_start = -1;
   endfunction

   function automatic void mark(input int t, input int k);
      if (t < MAXH) begin
         e_busy[t] = 1'b1;
         e_cur[t]  = k;
      end
   endfunction

   // Start accepted at end of cycle acc; returns done cycle or first error cycle
   function automatic int build_run(input int acc);
      int t;
      t = acc + 1;
      for (int k = 0; k < NS; k++) begin
         mark(t, k);
         if (t < MAXH) e_ss[t][k] = 1'b1;
         if (lat[k] <= TO) begin
            for (int w = 1; w <= lat[k]; w++) mark(t + w, k);
            t = t + lat[k] + 1;
         end else begin
            for (int w = 1; w <= TO; w++) mark(t + w, k);
            err_start = t + TO + 1;
            for (int e = err_start; e < MAXH; e++) begin
               mark(e, k);
               e_err[e] = 1'b1;
               e_es[e]  = k;
            end
            return err_start;
         end
      end
      mark(t, NS - 1);
      if (t < MAXH) e_done[t] = 1'b1;
      return t;
   endfunction

   // Abort sampled at end of cycle ab: everything afterwards is idle
   function automatic void apply_abort();
      if (ab >= 0) begin
         for (int e = ab + 1; e < MAXH; e++) begin
            e_ss[e] = '0; e_done[e] = 1'b0; e_busy[e] = 1'b0;
            e_err[e] = 1'b0; e_cur[e] = 0;
         end
      end
   endfunction

   function automatic int horizon(input int endp);
      return ((ab > endp) ? ab : endp) + 6;
   endfunction

   // Compare outputs each cycle at negedge, then drive inputs for that cycle
   task automatic run_trace(input int h, input bit hold, input string name);
      int            due [NS];
      logic [NS-1:0] dn;
      for (int k = 0; k < NS; k++) due[k] = -1;
      for (int r = 0; r < h; r++) begin
         @(negedge clk);
         chk($sformatf("%s.stage_start@%0d", name, r), 32'(bus_if.stage_start), 32'(e_ss[r]));
         chk($sformatf("%s.done@%0d", name, r), 32'(bus_if.done), 32'(e_done[r]));
         chk($sformatf("%s.busy@%0d", name, r), 32'(bus_if.busy), 32'(e_busy[r]));
         chk($sformatf("%s.error@%0d", name, r), 32'(bus_if.error), 32'(e_err[r]));
         chk($sformatf("%s.cur_stage@%0d", name, r), 32'(bus_if.cur_stage), e_cur[r]);
         if (e_err[r]) chk($sformatf("%s.err_stage@%0d", name, r), 32'(bus_if.err_stage), e_es[r]);
         for (int k = 0; k < NS; k++) if (bus_if.stage_start[k]) due[k] = r + lat[k];
         dn = stray[r];
         for (int k = 0; k < NS; k++) if (due[k] == r) dn[k] = 1'b1;
         bus_if.stage_done = dn;
         bus_if.start      = hold ? (r < h - 1) : ((r == 0) || xstart[r]);
         bus_if.abort      = (r == ab);
      end
      @(negedge clk);
      bus_if.stage_done = '0;
      bus_if.start      = 1'b0;
      bus_if.abort      = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".stage_start"}, 32'(bus_if.stage_start), 0);
      chk({name, ".done"}, 32'(bus_if.done), 0);
      chk({name, ".busy"}, 32'(bus_if.busy), 0);
      chk({name, ".error"}, 32'(bus_if.error), 0);
      chk({name, ".err_stage"}, 32'(bus_if.err_stage), 0);
      chk({name, ".cur_stage"}, 32'(bus_if.cur_stage), 0);
`ifdef SEQ_PERF_CNT_EN
      chk({name, ".perf_cycles"}, bus_if.perf_cycles, 0);
`endif
   endtask

   initial begin
      int endp;
      int d0;
      int d1;
      reset             = 1'b1;
      bus_if.start      = 1'b0;
      bus_if.abort      = 1'b0;
      bus_if.stage_done = '0;
`ifdef SEQ_PERF_CNT_EN
      bus_if.perf_stage_sel = '0;
`endif
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Normal run, each stage answers 3 cycles after its start
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      endp = build_run(0);
      run_trace(horizon(endp), 1'b0, "normal");

      // Stage 2 never answers: timeout, abort out of ERROR, then clean run
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      lat[2] = NEVER;
      endp = build_run(0);
      ab = err_start + 3;
      apply_abort();
      xstart[err_start + 1] = 1'b1;
      run_trace(horizon(endp), 1'b0, "timeout");
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      endp = build_run(0);
      run_trace(horizon(endp), 1'b0, "after_err");

      // Stray dones: done[0] during LAUNCH of 0, done[3] while waiting on 1
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      lat[1] = TO;
      stray[1][0] = 1'b1; stray[8][3] = 1'b1; stray[12][3] = 1'b1;
      endp = build_run(0);
      run_trace(horizon(endp), 1'b0, "stray_ok");
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      lat[1] = NEVER;
      stray[1][0] = 1'b1; stray[8][3] = 1'b1; stray[12][3] = 1'b1;
      endp = build_run(0);
      ab = err_start + 1;
      apply_abort();
      run_trace(horizon(endp), 1'b0, "stray_to");

      // Abort in WAIT on stage 3 coinciding with its done
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      lat[3] = $urandom_range(1, 8);
      endp = build_run(0);
      ab = 13 + lat[3];
      apply_abort();
      run_trace(horizon(endp), 1'b0, "abort_w3");

      // Randomized runs: latencies, boundary TIMEOUT, timeouts, aborts, stray starts
      for (int run = 0; run < 10; run++) begin
         clear_model();
         for (int k = 0; k < NS; k++) lat[k] = $urandom_range(1, 6);
         case ($urandom_range(0, 3))
            0: lat[$urandom_range(0, NS - 1)] = TO;
            1: lat[$urandom_range(0, NS - 1)] = TO + 1 + $urandom_range(0, 3);
            default: ;
         endcase
         endp = build_run(0);
         if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, endp);
         else if (err_start >= 0) ab = err_start + $urandom_range(0, 3);
         apply_abort();
         for (int r = 0; r < MAXH; r++) xstart[r] = e_busy[r] && ($urandom_range(0, 3) == 0);
         run_trace(horizon(endp), 1'b0, $sformatf("rnd%0d", run));
      end

      // Async reset mid-WAIT, between edges, then start held high
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      endp = build_run(0);
      run_trace(7, 1'b0, "pre_rst");
      chk("pre_rst.busy_hold", 32'(bus_if.busy), 1);
      #2 reset = 1'b1;
      #1 chk_all_zero("async_rst");
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("rst_held");
      reset = 1'b0;
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = 3;
      d0 = build_run(0);
      d1 = build_run(d0 + 1);
      run_trace(d1 + 2, 1'b1, "hold_start");

`ifdef SEQ_PERF_CNT_EN
      // Per-stage WAIT counts and total busy cycles of a run
      clear_model();
      for (int k = 0; k < NS; k++) lat[k] = k + 2;
      endp = build_run(0);
      run_trace(horizon(endp), 1'b0, "perf");
      d0 = 0;
      for (int r = 0; r < MAXH; r++) if (e_busy[r]) d0++;
      chk("perf.cycles", bus_if.perf_cycles, d0);
      for (int k = 0; k < NS; k++) begin
         bus_if.perf_stage_sel = 3'(k);
         #1 chk($sformatf("perf.stage%0d", k), bus_if.perf_stage_cycles, lat[k]);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
